// File: rtl/particle_ctl.sv
// particle_ctl: frame-rate ballistic trajectory controller for the thrown
// particle. It launches on a throw request and steps once per video frame.
// It detects a target hit, a ground miss or a screen-edge miss, holds at the
// impact point for a number of frames, then parks the particle off-screen.
module particle_ctl #(
  parameter int PARTICLE_WIDTH  = 64,
  parameter int PARTICLE_HEIGHT = 64,
  parameter int GRAVITY         = 1,
  parameter int GROUND_Y        = 700,
  parameter int SCREEN_W        = 1024,
  parameter int TARGET_W        = 128,
  parameter int TARGET_H        = 128,
  parameter int HOLD_FRAMES     = 30,
  parameter int PARK_X          = 2047,
  parameter int PARK_Y          = 2047
) (
  input  logic        clk60MHz,
  input  logic        rst_n,
  input  logic        vblnk,
  input  logic        throw,
  input  logic        thrower,
  input  logic [11:0] start_x,
  input  logic [11:0] start_y,
  input  logic [5:0]  vx0,
  input  logic [5:0]  vy0,
  input  logic [11:0] target_x,
  input  logic [11:0] target_y,
  output logic [11:0] xpos_particle,
  output logic [11:0] ypos_particle,
  output logic        turn,
  output logic        busy,
  output logic        hit,
  output logic        miss
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] FLIGHT = 2'd1;
  localparam logic [1:0] IMPACT = 2'd2;

  localparam logic signed [13:0] PW    = 14'(PARTICLE_WIDTH);
  localparam logic signed [13:0] PH    = 14'(PARTICLE_HEIGHT);
  localparam logic signed [13:0] GY    = 14'(GROUND_Y);
  localparam logic signed [13:0] SW    = 14'(SCREEN_W);
  localparam logic signed [13:0] TW    = 14'(TARGET_W);
  localparam logic signed [13:0] TH    = 14'(TARGET_H);
  localparam logic signed [8:0]  GRAV  = 9'(GRAVITY);
  localparam logic [11:0]        PX    = 12'(PARK_X);
  localparam logic [11:0]        PY    = 12'(PARK_Y);
  // A zero hold period still needs one tick to leave IMPACT.
  localparam logic [15:0]        HOLD_LOAD = 16'((HOLD_FRAMES == 0) ? 1 : HOLD_FRAMES);

  logic [1:0]         state;
  logic               vblnk_d;
  logic               tick;
  logic signed [13:0] x, y;
  logic [5:0]         vx;
  logic signed [7:0]  vy;
  logic [15:0]        hold_cnt;

  logic signed [13:0] x_n, y_n, tx, ty, x_cl, y_cl, imp_x, imp_y;
  logic signed [8:0]  vy_dec;
  logic signed [7:0]  vy_n;
  logic               hit_c, ground_c, edge_lo, edge_hi, impact_c;

  // Negative coordinates (above screen / left of screen) are shown as 0.
  function automatic logic [11:0] to_out(input logic signed [13:0] v);
    return (v < 0) ? 12'd0 : v[11:0];
  endfunction

  assign tick = vblnk & ~vblnk_d;

  // Next-frame kinematics, collision tests and clamped impact position.
  always_comb begin
    x_n      = turn ? (x - $signed({8'd0, vx})) : (x + $signed({8'd0, vx}));
    y_n      = y - {{6{vy[7]}}, vy};
    vy_dec   = {vy[7], vy} - GRAV;
    vy_n     = (vy_dec < -9'sd128) ? -8'sd128 : vy_dec[7:0];
    tx       = $signed({2'b00, target_x});
    ty       = $signed({2'b00, target_y});
    hit_c    = (x_n < tx + TW) && (tx < x_n + PW) &&
               (y_n < ty + TH) && (ty < y_n + PH);
    ground_c = (y_n + PH >= GY);
    edge_lo  = (x_n < 0);
    edge_hi  = (x_n + PW > SW);
    impact_c = hit_c || ground_c || edge_lo || edge_hi;
    x_cl     = edge_lo ? 14'sd0 : (edge_hi ? (SW - PW) : x_n);
    y_cl     = ground_c ? (GY - PH) : y_n;
    imp_x    = hit_c ? x_n : x_cl;
    imp_y    = hit_c ? y_n : y_cl;
  end

  // Frame-tick edge detector, trajectory state machine and registered outputs.
  always_ff @(posedge clk60MHz or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      vblnk_d       <= 1'b0;
      x             <= '0;
      y             <= '0;
      vx            <= '0;
      vy            <= '0;
      hold_cnt      <= '0;
      xpos_particle <= PX;
      ypos_particle <= PY;
      turn          <= 1'b0;
      busy          <= 1'b0;
      hit           <= 1'b0;
      miss          <= 1'b0;
    end else begin
      vblnk_d <= vblnk;
      hit     <= 1'b0;
      miss    <= 1'b0;
      case (state)
        IDLE: begin
          if (throw) begin
            turn          <= thrower;
            x             <= $signed({2'b00, start_x});
            y             <= $signed({2'b00, start_y});
            vx            <= vx0;
            vy            <= $signed({2'b00, vy0});
            xpos_particle <= start_x;
            ypos_particle <= start_y;
            busy          <= 1'b1;
            state         <= FLIGHT;
          end
        end
        FLIGHT: begin
          if (tick) begin
            if (impact_c) begin
              x             <= imp_x;
              y             <= imp_y;
              xpos_particle <= to_out(imp_x);
              ypos_particle <= to_out(imp_y);
              hit           <= hit_c;
              miss          <= ~hit_c;
              hold_cnt      <= HOLD_LOAD;
              state         <= IMPACT;
            end else begin
              x             <= x_n;
              y             <= y_n;
              vy            <= vy_n;
              xpos_particle <= to_out(x_n);
              ypos_particle <= to_out(y_n);
            end
          end
        end
        IMPACT: begin
          if (tick) begin
            if (hold_cnt <= 16'd1) begin
              hold_cnt      <= '0;
              xpos_particle <= PX;
              ypos_particle <= PY;
              busy          <= 1'b0;
              state         <= IDLE;
            end else begin
              hold_cnt <= hold_cnt - 16'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_particle_ctl.sv
// Directed bench for particle_ctl: hand-computed trajectories for launch,
// ground, target hit and screen-edge cases, hold timing, relaunch and reset.
module tb_particle_ctl;

  logic        clk60MHz = 1'b0;
  logic        rst_n    = 1'b0;
  logic        vblnk    = 1'b0;
  logic        throw    = 1'b0;
  logic        thrower  = 1'b0;
  logic [11:0] start_x  = '0;
  logic [11:0] start_y  = '0;
  logic [5:0]  vx0      = '0;
  logic [5:0]  vy0      = '0;
  logic [11:0] target_x = 12'd4000;
  logic [11:0] target_y = 12'd4000;
  logic [11:0] xpos_particle, ypos_particle;
  logic        turn, busy, hit, miss;

  int vectors = 0;
  int errors  = 0;
  int hit_cnt = 0;
  int miss_cnt = 0;

  particle_ctl #(
    .PARTICLE_WIDTH(64), .PARTICLE_HEIGHT(64), .GRAVITY(1), .GROUND_Y(700),
    .SCREEN_W(1024), .TARGET_W(128), .TARGET_H(128), .HOLD_FRAMES(30),
    .PARK_X(2047), .PARK_Y(2047)
  ) dut (
    .clk60MHz(clk60MHz), .rst_n(rst_n), .vblnk(vblnk), .throw(throw),
    .thrower(thrower), .start_x(start_x), .start_y(start_y), .vx0(vx0),
    .vy0(vy0), .target_x(target_x), .target_y(target_y),
    .xpos_particle(xpos_particle), .ypos_particle(ypos_particle),
    .turn(turn), .busy(busy), .hit(hit), .miss(miss)
  );

  always #5 clk60MHz = ~clk60MHz;

  // Count pulse cycles away from the active edge.
  always @(negedge clk60MHz) begin
    if (hit === 1'b1)  hit_cnt++;
    if (miss === 1'b1) miss_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_pos(input string tag, input int ex, input int ey);
    check({tag, ".x"}, 32'(xpos_particle), 32'(ex));
    check({tag, ".y"}, 32'(ypos_particle), 32'(ey));
  endtask

  // One frame tick: the edge after vblnk rises is the tick edge; returns #1 after it.
  task automatic do_tick();
    @(posedge clk60MHz); #1 vblnk = 1'b1;
    @(posedge clk60MHz); #1 vblnk = 1'b0;
  endtask

  task automatic setup(input logic thr, input int sx, input int sy, input int vx, input int vy);
    thrower = thr;
    start_x = 12'(sx);
    start_y = 12'(sy);
    vx0     = 6'(vx);
    vy0     = 6'(vy);
  endtask

  task automatic pulse_throw();
    @(posedge clk60MHz); #1 throw = 1'b1; start_x = 12'd10; start_y = 12'd10;
    @(posedge clk60MHz); #1 throw = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk60MHz);
    #1;
    check_pos("reset", 2047, 2047);
    check("reset.busy", 32'(busy), 0);
    check("reset.turn", 32'(turn), 0);
    check("reset.hit",  32'(hit), 0);
    check("reset.miss", 32'(miss), 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk60MHz);
    #1;
    check("idle.busy", 32'(busy), 0);

    // Rightward arc to apex
    setup(1'b0, 100, 500, 8, 10);
    throw = 1'b1;
    @(posedge clk60MHz); #1 throw = 1'b0;
    check_pos("v1.launch", 100, 500);
    check("v1.busy", 32'(busy), 1);
    check("v1.turn", 32'(turn), 0);
    do_tick();
    check_pos("v1.t1", 108, 490);
    for (int i = 2; i <= 10; i++) do_tick();
    check_pos("v1.t10", 180, 445);
    do_tick();
    check_pos("v1.apex", 188, 445);
    rst_n = 1'b0;
    #3 rst_n = 1'b1;

    // Leftward drop to the ground, hold, then park
    target_x = 12'd0; target_y = 12'd0;
    @(posedge clk60MHz); #1;
    setup(1'b1, 900, 500, 4, 0);
    throw = 1'b1;
    @(posedge clk60MHz); #1 throw = 1'b0;
    check("v2.turn", 32'(turn), 1);
    do_tick(); check_pos("v2.t1", 896, 500);
    do_tick(); check_pos("v2.t2", 892, 501);
    do_tick(); check_pos("v2.t3", 888, 503);
    do_tick(); check_pos("v2.t4", 884, 506);
    pulse_throw();
    check_pos("v2.throw_ign", 884, 506);
    do_tick(); check_pos("v2.t5", 880, 510);
    for (int i = 6; i <= 16; i++) do_tick();
    check_pos("v2.t16", 836, 620);
    check("v2.no_miss_yet", 32'(miss_cnt), 0);
    do_tick();
    check_pos("v2.ground", 832, 636);
    check("v2.miss", 32'(miss), 1);
    check("v2.hit", 32'(hit), 0);
    @(posedge clk60MHz); #1;
    check("v2.miss_1cyc", 32'(miss), 0);
    for (int i = 1; i <= 29; i++) begin
      do_tick();
      if (i == 5) pulse_throw();
    end
    check("v2.hold_busy", 32'(busy), 1);
    check_pos("v2.hold_pos", 832, 636);
    do_tick();
    check("v2.park_busy", 32'(busy), 0);
    check_pos("v2.park", 2047, 2047);
    check("v2.turn_kept", 32'(turn), 1);
    check("v2.miss_cnt", 32'(miss_cnt), 1);
    check("v2.hit_cnt", 32'(hit_cnt), 0);

    // Target hit with throw held high, then relaunch into a screen-edge miss
    target_x = 12'd300; target_y = 12'd400;
    setup(1'b0, 230, 420, 20, 0);
    @(posedge clk60MHz); #1 throw = 1'b1;
    @(posedge clk60MHz); #1;
    check_pos("v3.launch", 230, 420);
    do_tick();
    check("v3.hit", 32'(hit), 1);
    check("v3.miss", 32'(miss), 0);
    check_pos("v3.hit_pos", 250, 420);
    for (int i = 1; i <= 29; i++) do_tick();
    check_pos("v3.frozen", 250, 420);
    check("v3.hold_busy", 32'(busy), 1);
    setup(1'b0, 950, 300, 20, 0);
    do_tick();
    check("v3.idle_busy", 32'(busy), 0);
    check_pos("v3.park", 2047, 2047);
    @(posedge clk60MHz); #1 throw = 1'b0;
    check("v3.relaunch_busy", 32'(busy), 1);
    check_pos("v3.relaunch", 950, 300);
    check("v3.hit_cnt", 32'(hit_cnt), 1);
    check("v3.miss_cnt", 32'(miss_cnt), 1);
    do_tick();
    check_pos("v4.edge", 960, 300);
    check("v4.miss", 32'(miss), 1);
    check("v4.hit", 32'(hit), 0);
    @(posedge clk60MHz); #1;
    check("v4.miss_cnt", 32'(miss_cnt), 2);
    check("v4.hit_cnt", 32'(hit_cnt), 1);
    rst_n = 1'b0;
    #3 rst_n = 1'b1;

    // Asynchronous reset mid-flight
    @(posedge clk60MHz); #1;
    setup(1'b1, 500, 300, 4, 0);
    throw = 1'b1;
    @(posedge clk60MHz); #1 throw = 1'b0;
    do_tick();
    check_pos("v5.t1", 496, 300);
    check("v5.turn", 32'(turn), 1);
    @(posedge clk60MHz); #3 rst_n = 1'b0;
    #1;
    check_pos("v5.rst", 2047, 2047);
    check("v5.rst_busy", 32'(busy), 0);
    check("v5.rst_turn", 32'(turn), 0);
    repeat (3) @(posedge clk60MHz);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk60MHz);
    #1;
    check("v5.hit_cnt", 32'(hit_cnt), 1);
    check("v5.miss_cnt", 32'(miss_cnt), 2);
    check("v5.idle", 32'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
